// File: rtl/mux_scan_sequencer_if.sv
// Signal bundle between the mux scan sequencer, its word source, the 16:1
// mux it drives, and the serial consumer.
interface mux_scan_sequencer_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [15:0] di;
  logic [3:0]  si;
  logic        y_in;
  logic        ser_out;
  logic        ser_valid;
  logic        ser_ready;
  logic        busy;
  logic        done;

  // Environment side: word source, mux feedback and serial consumer.
  modport master (
    output load_valid, load_data, y_in, ser_ready,
    input  load_ready, di, si, ser_out, ser_valid, busy, done
  );

  // Sequencer side.
  modport slave (
    input  load_valid, load_data, y_in, ser_ready,
    output load_ready, di, si, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Parallel-in / serial-out converter built around an external 16:1 mux.
// A loaded word is held on the mux data inputs while the select sweeps all
// sixteen positions; after each select change the mux output is sampled
// once it has settled and offered on a serial valid/ready stream.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a word; load_ready high
// SETTLE | select just changed, counting HOLD_CYCLES before sampling y_in
// OUT    | sampled bit presented on ser_out, waiting for ser_ready
module mux_scan_sequencer #(
  parameter int HOLD_CYCLES = 1,   // legal 1..15
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.slave  bus_if
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  localparam logic [3:0] SI_FIRST = MSB_FIRST ? 4'd15 : 4'd0;
  localparam logic [3:0] SI_LAST  = MSB_FIRST ? 4'd0  : 4'd15;
  localparam logic [3:0] CNT_LAST = 4'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic [15:0] di_q;
  logic [3:0]  si_q;
  logic [3:0]  cnt_q;
  logic        ser_out_q;
  logic        ser_valid_q;
  logic        done_q;
  logic        load_ready_w;

  assign load_ready_w = (state_q == IDLE);

  // Sequencing FSM: load, settle, sample, hand off, step the select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      di_q        <= 16'h0000;
      si_q        <= 4'd0;
      cnt_q       <= 4'd0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus_if.load_valid && load_ready_w) begin
            di_q    <= bus_if.load_data;
            si_q    <= SI_FIRST;
            cnt_q   <= 4'd0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            ser_out_q   <= bus_if.y_in;
            ser_valid_q <= 1'b1;
            cnt_q       <= 4'd0;
            state_q     <= OUT;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        OUT: begin
          if (bus_if.ser_ready) begin
            ser_valid_q <= 1'b0;
            if (si_q == SI_LAST) begin
              // Sweep ends here; si and di keep their final values.
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              si_q    <= MSB_FIRST ? (si_q - 4'd1) : (si_q + 4'd1);
              state_q <= SETTLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.load_ready = load_ready_w;
  assign bus_if.busy       = (state_q != IDLE);
  assign bus_if.di         = di_q;
  assign bus_if.si         = si_q;
  assign bus_if.ser_out    = ser_out_q;
  assign bus_if.ser_valid  = ser_valid_q;
  assign bus_if.done       = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer: three configurations, each wired
// to a behavioural 16:1 mux, exercised by one linear stimulus sequence.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_scan_sequencer_if if0 ();  // HOLD=1, LSB first
  mux_scan_sequencer_if if1 ();  // HOLD=1, MSB first
  mux_scan_sequencer_if if2 ();  // HOLD=3, LSB first

  assign if0.y_in = if0.di[if0.si];
  assign if1.y_in = if1.di[if1.si];
  assign if2.y_in = if2.di[if2.si];

  mux_scan_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u0 (.clk(clk), .rst(rst), .bus_if(if0.slave));
  mux_scan_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b1)) u1 (.clk(clk), .rst(rst), .bus_if(if1.slave));
  mux_scan_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b0)) u2 (.clk(clk), .rst(rst), .bus_if(if2.slave));

  logic [15:0] s_di;
  logic [3:0]  s_si;
  logic        s_out, s_valid, s_busy, s_done, s_lr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int w);
    case (w)
      0: begin s_di = if0.di; s_si = if0.si; s_out = if0.ser_out; s_valid = if0.ser_valid;
               s_busy = if0.busy; s_done = if0.done; s_lr = if0.load_ready; end
      1: begin s_di = if1.di; s_si = if1.si; s_out = if1.ser_out; s_valid = if1.ser_valid;
               s_busy = if1.busy; s_done = if1.done; s_lr = if1.load_ready; end
      default: begin s_di = if2.di; s_si = if2.si; s_out = if2.ser_out; s_valid = if2.ser_valid;
               s_busy = if2.busy; s_done = if2.done; s_lr = if2.load_ready; end
    endcase
  endtask

  task automatic drive(input int w, input logic lv, input logic [15:0] ld, input logic sr);
    case (w)
      0: begin if0.load_valid = lv; if0.load_data = ld; if0.ser_ready = sr; end
      1: begin if1.load_valid = lv; if1.load_data = ld; if1.ser_ready = sr; end
      default: begin if2.load_valid = lv; if2.load_data = ld; if2.ser_ready = sr; end
    endcase
  endtask

  task automatic chk_reset(input int w, input string tag);
    snap(w);
    chk({tag, "_load_ready"}, 32'(s_lr), 32'd1);
    chk({tag, "_di"}, 32'(s_di), 32'd0);
    chk({tag, "_si"}, 32'(s_si), 32'd0);
    chk({tag, "_ser_out"}, 32'(s_out), 32'd0);
    chk({tag, "_ser_valid"}, 32'(s_valid), 32'd0);
    chk({tag, "_busy"}, 32'(s_busy), 32'd0);
    chk({tag, "_done"}, 32'(s_done), 32'd0);
  endtask

  // Load one word and follow it to done. Expected bit order, select values
  // and per-bit timing are derived from the word, direction and hold time.
  task automatic run_word(input int w, input logic [15:0] word, input bit msb, input int hold,
                          input int stall_si, input int stall_len, input bit junk, input string tag);
    int          cyc, n, idx, extra, dones, done_cyc, limit;
    bit          stalled;
    logic [15:0] wv;
    wv = word; n = 0; extra = 0; dones = 0; done_cyc = -1; stalled = 1'b0;
    limit = 16 * (hold + 1) + stall_len + 8;
    snap(w);
    chk({tag, "_ready_before"}, 32'(s_lr), 32'd1);
    drive(w, 1'b1, word, 1'b1);
    step();
    cyc = 0;
    drive(w, junk, 16'hFFFF, 1'b1);
    while (cyc < limit) begin
      step();
      cyc++;
      snap(w);
      chk({tag, "_di_hold"}, 32'(s_di), 32'(word));
      if (s_valid && !stalled && stall_len > 0 && int'(s_si) == stall_si) begin
        stalled = 1'b1;
        idx = msb ? 15 - n : n;
        drive(w, junk, 16'hFFFF, 1'b0);
        for (int k = 0; k < stall_len; k++) begin
          step();
          cyc++;
          snap(w);
          chk({tag, "_stall_valid"}, 32'(s_valid), 32'd1);
          chk({tag, "_stall_si"}, 32'(s_si), 32'(stall_si));
          chk({tag, "_stall_bit"}, 32'(s_out), 32'(wv[idx]));
          chk({tag, "_stall_di"}, 32'(s_di), 32'(word));
        end
        extra = stall_len;
        drive(w, junk, 16'hFFFF, 1'b1);
      end
      if (s_valid) begin
        if (n < 16) begin
          idx = msb ? 15 - n : n;
          chk({tag, "_bit"}, 32'(s_out), 32'(wv[idx]));
          chk({tag, "_si"}, 32'(s_si), 32'(idx));
          chk({tag, "_valid_cycle"}, 32'(cyc), 32'(n * (hold + 1) + hold + extra));
          chk({tag, "_ready_busy"}, 32'(s_lr), 32'd0);
        end
        n++;
      end
      if (s_done) begin
        dones++;
        done_cyc = cyc;
        chk({tag, "_ready_at_done"}, 32'(s_lr), 32'd1);
        drive(w, 1'b0, 16'h0000, 1'b1);
      end
    end
    snap(w);
    chk({tag, "_bit_count"}, 32'(n), 32'd16);
    chk({tag, "_done_count"}, 32'(dones), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(16 * (hold + 1) + stall_len));
    chk({tag, "_si_final"}, 32'(s_si), msb ? 32'd0 : 32'd15);
    chk({tag, "_busy_after"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    bit found;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 16'h0000, 1'b1);
    #23;
    chk_reset(0, "rst0");
    chk_reset(1, "rst1");
    chk_reset(2, "rst2");
    rst = 1'b0;
    step();

    run_word(0, 16'hA5C3, 1'b0, 1, -1, 0, 1'b0, "lsb");
    run_word(1, 16'h8001, 1'b1, 1, -1, 0, 1'b0, "msb");
    run_word(0, 16'h5A69, 1'b0, 1, 3, 5, 1'b0, "bp");
    run_word(2, 16'hC35A, 1'b0, 3, -1, 0, 1'b0, "hold3");
    run_word(0, 16'h3C96, 1'b0, 1, -1, 0, 1'b1, "busyload");
    run_word(0, 16'h00FF, 1'b0, 1, -1, 0, 1'b0, "afterbusy");

    // Asynchronous reset in the middle of a word, between clock edges.
    drive(0, 1'b1, 16'hF0F0, 1'b1);
    step();
    drive(0, 1'b0, 16'h0000, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      snap(0);
      if (s_si == 4'd7 && s_busy) found = 1'b1;
    end
    chk("midrst_reach_si7", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset(0, "midrst");
    #1 rst = 1'b0;
    run_word(0, 16'h0001, 1'b0, 1, -1, 0, 1'b0, "postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
Upstream driver and sampler for the 16:1 select mux in the data-flow library. It accepts a 16-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the 4-bit select through all 16 positions. It samples the mux output after a programmable settle time and emits each sampled bit on a serial valid/ready stream. The result is a parallel-in/serial-out converter built around the existing mux.

Parameters:
- HOLD_CYCLES, default 1: clocks between a select change and the sample of y_in. Legal range is 1..15.
- MSB_FIRST, default 0: 0 sweeps si 0→15 (LSB first); 1 sweeps si 15→0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a new word.
- load_data  input  16  word to serialise.
- di  output  16  registered word, drives the mux data inputs.
- si  output  4  registered select, drives the mux select inputs.
- y_in  input  1  mux output, fed back combinationally from the mux.
- ser_out  output  1  sampled serial bit.
- ser_valid  output  1  ser_out is valid.
- ser_ready  input  1  consumer accepts ser_out.
- busy  output  1  a word is in progress.
- done  output  1  one-cycle pulse after the last bit is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1, all state clears immediately.
- Reset values: state=IDLE, load_ready=1, di=0, si=0, ser_out=0, ser_valid=0, busy=0, done=0, settle counter=0.
- All outputs are registered. load_ready is high only in IDLE (registered, or a pure decode of the state register). busy = not IDLE.
- Interface to the mux: di and si connect directly to the mux inputs, and y_in is the mux output. There is no combinational path from y_in to any output.
- FSM states: IDLE, SETTLE, OUT.
- IDLE:
  - On the edge where load_valid & load_ready: di←load_data; si←0 (MSB_FIRST=0) or 15 (MSB_FIRST=1); cnt←0; go to SETTLE.
  - Otherwise hold. ser_valid stays 0.
- SETTLE:
  - cnt increments each clock.
  - On the edge where cnt==HOLD_CYCLES-1: ser_out←y_in, ser_valid←1, cnt←0, go to OUT.
  - si and di are stable throughout.
- OUT:
  - ser_valid=1. ser_out, si and di are held until ser_valid & ser_ready.
  - On handshake, not last bit: si←si+1 (MSB_FIRST=0) or si−1 (MSB_FIRST=1); ser_valid←0; go to SETTLE.
  - On handshake, last bit (si==15 for MSB_FIRST=0, si==0 for MSB_FIRST=1): ser_valid←0, done←1 for exactly one cycle, go to IDLE. si and di keep their final values.
- Wrap-around: si never wraps. The sweep terminates at the end index.
- Latency:
  - First ser_valid rises HOLD_CYCLES edges after the load-accept edge.
  - With ser_ready held at 1, each bit occupies HOLD_CYCLES+1 cycles, so a word takes 16*(HOLD_CYCLES+1) cycles from accept to the done edge.
  - load_ready returns high in the cycle done is high. Back-to-back loads are therefore possible with one cycle of gap.
- Boundary conditions:
  - load_valid while busy: ignored; di is not modified.
  - ser_ready high while ser_valid low: ignored.
  - ser_ready low: stalls indefinitely in OUT with no state change.
  - Reset mid-word: outputs return to reset values asynchronously. The next accepted load restarts from the first index.
  - No abort input.

Test Plan:
- LSB-first stream: HOLD_CYCLES=1, MSB_FIRST=0, ser_ready=1, load 16'hA5C3, mux connected.
  - ser_out over 16 handshakes = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - si steps 0..15.
  - done pulses exactly 32 cycles after the accept edge.
- MSB-first stream: MSB_FIRST=1, load 16'h8001.
  - si steps 15→0.
  - ser_out = 1, then fourteen 0s, then 1.
  - done asserted once.
- Backpressure: drop ser_ready for 5 cycles when si=3 with ser_valid=1.
  - ser_out, ser_valid=1, si=3 and di all stay stable for 5 cycles.
  - The stream resumes at si=4 with no lost or duplicated bit.
- Settle time: HOLD_CYCLES=3.
  - ser_valid rises exactly 3 edges after accept and after every select step.
  - The whole word takes 64 cycles.
- Load while busy: assert load_valid with 16'hFFFF during a word in progress.
  - load_ready=0, di unchanged, original bits unaffected.
  - After done, the next load is accepted with load_ready=1.
- Reset mid-word: pulse rst asynchronously (between clock edges) at si=7.
  - All outputs reach reset values immediately.
  - The next load of 16'h0001 yields ser_out=1 as the first bit, at si=0.
